// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read-side pop interface plus the packed-word
// valid/ready output bus of fifo_rd_packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_rd_packer_if #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned LANES = 4,
   parameter int unsigned CW    = $clog2(LANES + 1)
);
   logic [DSIZE-1:0]       rdata;
   logic                   rempty;
   logic                   rinc;
   logic [DSIZE*LANES-1:0] out_data;
   logic [CW-1:0]          out_cnt;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      input  rdata, rempty, out_ready,
      output rinc, out_data, out_cnt, out_valid
   );

   modport slave (
      output rdata, rempty, out_ready,
      input  rinc, out_data, out_cnt, out_valid
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains DSIZE-bit entries from the dual-clock FIFO read port
// and packs LANES consecutive entries (lane 0 = oldest) into one wide word,
// presented on a valid/ready output. Read-clock domain only.
// Optional feature: define PACKER_TIMEOUT_EN to flush a partial word after
// TO_CYCLES idle cycles; otherwise partial words wait indefinitely.
module fifo_rd_packer #(
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned LANES     = 4,
   parameter int unsigned TO_CYCLES = 16,
   parameter int unsigned CW        = $clog2(LANES + 1)
) (
   input  logic             rclk,
   input  logic             rrst_n,
   fifo_rd_packer_if.master bus
);

   localparam logic [CW-1:0] FULL = CW'(LANES);

   if (LANES < 2 || TO_CYCLES < 1) begin : g_bad_cfg
      $error("fifo_rd_packer: LANES must be >= 2 and TO_CYCLES >= 1");
   end

   logic [DSIZE*LANES-1:0] acc_q, acc_d;
   logic [CW-1:0]          acc_cnt_q, acc_cnt_d;
   logic [DSIZE*LANES-1:0] out_data_q, out_data_d;
   logic [CW-1:0]          out_cnt_q, out_cnt_d;
   logic                   out_valid_q, out_valid_d;

   logic                   out_free;
   logic                   xfer;
   logic                   pop;
   logic                   flush;
   int unsigned            wr_lane;

   // Handshake decisions: output slot free, full-word transfer, FIFO pop
   always_comb begin
      out_free = ~out_valid_q | bus.out_ready;
      xfer     = (acc_cnt_q == FULL) & out_free;
      pop      = ~bus.rempty & ((acc_cnt_q < FULL) | xfer);
   end

`ifdef PACKER_TIMEOUT_EN
   localparam int unsigned   TW     = $clog2(TO_CYCLES + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TO_CYCLES);

   logic [TW-1:0] tcnt_q, tcnt_d;

   // tcnt only reaches TO_MAX while a partial word sits idle
   assign flush = (tcnt_q == TO_MAX) & bus.rempty & out_free;

   // Idle counter: counts pop-less cycles of a partial word, saturating
   always_comb begin
      tcnt_d = tcnt_q;
      if (pop || acc_cnt_q == '0 || flush) begin
         tcnt_d = '0;
      end else if (acc_cnt_q < FULL && tcnt_q != TO_MAX) begin
         tcnt_d = tcnt_q + TW'(1);
      end
   end

   // Idle counter register
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign flush = 1'b0;
`endif

   // Accumulator: clear on transfer/flush, then write the popped entry
   // into lane 0 (transfer cycle) or the next free lane
   always_comb begin
      acc_d     = acc_q;
      acc_cnt_d = acc_cnt_q;
      wr_lane   = xfer ? 32'd0 : 32'(acc_cnt_q);
      if (xfer || flush) begin
         acc_d     = '0;
         acc_cnt_d = '0;
      end
      if (pop) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (i == wr_lane) begin
               acc_d[i*DSIZE +: DSIZE] = bus.rdata;
            end
         end
         acc_cnt_d = xfer ? CW'(1) : acc_cnt_q + CW'(1);
      end
   end

   // Output register: load on transfer or flush, drop valid on acceptance
   always_comb begin
      out_data_d  = out_data_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_data_d  = acc_q;
         out_cnt_d   = FULL;
         out_valid_d = 1'b1;
      end else if (flush) begin
         out_data_d  = acc_q;
         out_cnt_d   = acc_cnt_q;
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any partially assembled word
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_data_q  <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_cnt_q   <= acc_cnt_d;
         out_data_q  <= out_data_d;
         out_cnt_q   <= out_cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.rinc      = pop;
   assign bus.out_data  = out_data_q;
   assign bus.out_cnt   = out_cnt_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage for the dual-clock FIFO. Runs entirely in the FIFO read clock domain. Pops DSIZE-bit entries through the FIFO's `rempty`/`rinc`/`rdata` interface and packs LANES consecutive entries into one wide word. Presents each word to a downstream consumer over a valid/ready handshake.

## Interface
- `DSIZE`, 8: width of one FIFO entry; must match the FIFO's DSIZE.
- `LANES`, 4: entries packed per output word; must be ≥2.
- `TO_CYCLES`, 16: idle cycles before a partial word is flushed; must be ≥1 (used only when PACKER_TIMEOUT_EN is defined).
- `CW`, $clog2(LANES+1): width of the lane-count fields.

Ports (name, direction, width, meaning):
- `rclk` input 1: read-domain clock; every register in the block is clocked on its rising edge.
- `rrst_n` input 1: asynchronous, active-low reset.
- `rdata` input DSIZE: FIFO head entry; valid whenever `rempty`=0, same cycle.
- `rempty` input 1: FIFO empty flag.
- `rinc` output 1: pop strobe to FIFO; combinational.
- `out_data` output DSIZE*LANES: packed word. Lane i occupies bits [i*DSIZE +: DSIZE]. Lane 0 holds the earliest-popped entry.
- `out_cnt` output CW: number of valid lanes in `out_data`, range 1..LANES.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: consumer accepts the word.

## Operation
- Internal registers:
  - accumulator `acc` (DSIZE*LANES);
  - accumulator fill count `acc_cnt` (CW bits, range 0..LANES);
  - output register set `out_data`/`out_cnt`/`out_valid`.
- `out_free` = !out_valid | out_ready.
- `xfer` = (acc_cnt==LANES) & out_free.
- Pop rule: `rinc` = !rempty & ((acc_cnt<LANES) | xfer). `rinc` is never 1 while `rempty`=1.
- On a pop, `rdata` is written into lane `acc_cnt`, or into lane 0 if `xfer` fires in the same cycle.
- `acc_cnt` update on each edge:
  - xfer & pop: 1.
  - xfer only: 0.
  - pop only: acc_cnt+1.
  - otherwise: hold.
- On `xfer`: out_data←acc, out_cnt←LANES, out_valid←1.
- If `out_valid` & `out_ready` and there is no transfer that cycle: out_valid←0. `out_data` holds its value.
- Backpressure: while `out_valid`=1 and `out_ready`=0:
  - `out_data`, `out_cnt` and `out_valid` hold stable;
  - the accumulator continues to fill up to LANES entries, then `rinc` stalls.
- Lane bits above `acc_cnt` in `acc` are zero. `acc` is cleared to zero on every transfer, with lane 0 then loaded if a pop occurs in that cycle.
- Reset, asynchronous and possible mid-operation:
  - acc=0, acc_cnt=0, out_data=0, out_cnt=0, out_valid=0;
  - timeout counter=0;
  - a partially assembled word is discarded.

## Timing
- Latency: the LANES-th pop at edge N makes acc_cnt=LANES. `out_valid` rises after edge N+1 provided `out_free` holds in cycle N+1.
- Throughput: with `rempty`=0 and `out_ready`=1 continuously, `rinc` stays high every cycle. One word is produced every LANES cycles, with no bubbles.
- Handshake: a word is consumed in a cycle where out_valid & out_ready are both 1. `out_ready` may be 1 while `out_valid`=0; this has no effect.
- `out_valid` never drops without acceptance.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - Timeout counter `tcnt`, width $clog2(TO_CYCLES+1). It increments each cycle where 0<acc_cnt<LANES and no pop occurs, saturating at TO_CYCLES. It clears on any pop or when acc_cnt==0.
  - Flush condition: tcnt==TO_CYCLES & rempty & out_free.
  - Flush action: out_data←acc (unused lanes zero), out_cnt←acc_cnt, out_valid←1, acc_cnt←0, tcnt←0.
  - No pop occurs in a flush cycle, since `rempty`=1.
- Not defined:
  - No counter exists; partial words wait indefinitely.
  - `out_cnt` equals LANES whenever `out_valid`=1.
  - `TO_CYCLES` is ignored.

## Test plan
- Reset: assert `rrst_n`=0 mid-fill with acc_cnt=2 -> immediately out_valid=0, out_cnt=0, out_data=0. After release, the next word starts at lane 0 with no stale entries.
- Streaming: DSIZE=8, LANES=4, FIFO preloaded 0x01..0x08, `out_ready`=1 -> `rinc` high for 8 consecutive cycles. Words 0x04030201 then 0x08070605, each with out_cnt=4, emitted 4 cycles apart.
- Backpressure: same data with `out_ready`=0 -> after 0x04030201 is presented, pops 0x05..0x08 then `rinc`=0. `out_data` stays stable. Raise `out_ready` for 1 cycle -> 0x08070605 appears on the next cycle and popping resumes.
- Empty gaps: one entry every 3 cycles, values 0xA0..0xA3 -> a single word 0xA3A2A1A0. `rinc` is never 1 while `rempty`=1.
- Timeout (PACKER_TIMEOUT_EN, TO_CYCLES=16): push 0x11, 0x22 then FIFO stays empty -> out_valid rises 17 cycles after the last pop, with out_data=0x00002211 and out_cnt=2. Without the macro: no output after 1000 cycles.
- Simultaneous transfer and pop: acc full, out_valid=1, out_ready=1, `rempty`=0 in the same cycle -> word accepted, new word loaded, next entry lands in lane 0, acc_cnt=1.
